// File: rtl/icache_pkg.sv
// Shared types and constants for the set-associative instruction cache.
// FSM state encoding, AXI encodings and a constant-evaluable log2 helper.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_MISS_R,
    S_RESP
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/icache_tag_bank.sv
// One way's valid/tag array: combinational lookup at i_idx, one write per cycle.
// Latency 0 for compare, 1 cycle for writes; no backpressure (always accepts writes).
module icache_tag_bank
  import icache_pkg::*;
#(
  parameter int SETS  = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_vld,
  output logic             o_hit,
  input  logic             i_wr_en,
  input  logic             i_wr_vld,
  input  logic             i_inv_all
);

  logic [SETS-1:0]  r_vld;
  logic [TAG_W-1:0] r_tag [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (i_inv_all) begin
      r_vld <= '0;
    end else if (i_wr_en) begin
      r_vld[i_idx] <= i_wr_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_tag[i_idx] <= i_tag;
  end

  assign o_vld = r_vld[i_idx];
  assign o_hit = o_vld && (r_tag[i_idx] == i_tag);

endmodule

// File: rtl/icache_sa.sv
// Set-associative icache, AXI4 AR/R refill, round-robin replacement; optional ICACHE_PERF_EN counters.
// Hit: resp 2 cycles after accept; miss: AR + BEATS beats; holds AR/resp until ready, one request in flight.
module icache_sa
  import icache_pkg::*;
#(
  parameter int CACHE_SIZE = 4096,
  parameter int LINE_SIZE  = 64,
  parameter int WAYS       = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              fence_i,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss
`endif
);

  localparam int BW     = log2(DATA_W / 8);
  localparam int BEATS  = LINE_SIZE / (DATA_W / 8);
  localparam int SETS   = CACHE_SIZE / (LINE_SIZE * WAYS);
  localparam int OFF_W  = log2(LINE_SIZE);
  localparam int IDX_W  = log2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? log2(WAYS) : 1;
  localparam int BEAT_W = (BEATS > 1) ? log2(BEATS) : 1;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [WAY_W-1:0]  r_way;
  logic [WAY_W-1:0]  r_rr [SETS];
  logic [BEAT_W-1:0] r_beat;
  logic              r_err;
  logic              r_flush_pend;
  logic [DATA_W-1:0] r_data [WAYS][SETS][BEATS];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [BEAT_W-1:0] w_word;
  logic [WAYS-1:0]   w_vld, w_hit;
  logic              w_any_hit;
  logic [WAY_W-1:0]  w_hit_way, w_victim, w_wr_way;
  logic              w_tag_we, w_tag_wvld, w_flush, w_err_now, w_beat_ok;

  assign w_idx  = r_addr[OFF_W +: IDX_W];
  assign w_tag  = r_addr[OFF_W+IDX_W +: TAG_W];
  assign w_word = (BEATS > 1) ? BEAT_W'(r_addr >> BW) : '0;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_tag_bank #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_tag (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_idx     (w_idx),
      .i_tag     (w_tag),
      .o_vld     (w_vld[g]),
      .o_hit     (w_hit[g]),
      .i_wr_en   (w_tag_we && (w_wr_way == WAY_W'(g))),
      .i_wr_vld  (w_tag_wvld),
      .i_inv_all (w_flush)
    );
  end

  // Descending scan so the lowest-index hit / invalid way wins.
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_way = '0;
    w_victim  = r_rr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit[w]) begin
        w_any_hit = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_vld[w]) w_victim = WAY_W'(w);
    end
  end

  assign w_wr_way  = (r_state == S_LOOKUP) ? w_victim : r_way;
  assign w_beat_ok = (r_beat == BEAT_W'(BEATS - 1));
  assign w_err_now = r_err || (rresp != RESP_OKAY) || (rlast && !w_beat_ok);

  always_comb begin
    w_next     = r_state;
    w_tag_we   = 1'b0;
    w_tag_wvld = 1'b0;
    w_flush    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_flush_pend) w_flush = 1'b1;
        else if (req_valid && req_ready) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_any_hit) begin
          w_next = S_RESP;
        end else begin
          // Victim is invalidated up front so an aborted or failed refill never leaves stale data visible.
          w_next   = S_MISS_AR;
          w_tag_we = 1'b1;
        end
      end
      S_MISS_AR: if (arready) w_next = S_MISS_R;
      S_MISS_R: begin
        if (rvalid && rlast) begin
          w_next     = S_RESP;
          w_tag_we   = !w_err_now;
          w_tag_wvld = 1'b1;
        end
      end
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // flush_pend comes out of reset set: keeps req_ready low through the reset cycle and is harmless to replay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_way        <= '0;
      r_beat       <= '0;
      r_err        <= 1'b0;
      r_flush_pend <= 1'b1;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else begin
      r_state      <= w_next;
      r_flush_pend <= fence_i || (r_flush_pend && !w_flush);
      if (req_valid && req_ready) r_addr <= req_addr;
      if (r_state == S_LOOKUP) r_way <= w_any_hit ? w_hit_way : w_victim;
      if (r_state == S_MISS_R && rvalid) begin
        r_err  <= w_err_now;
        r_beat <= (rlast || w_beat_ok) ? '0 : r_beat + 1'b1;
        if (rlast && !w_err_now) r_rr[w_idx] <= (WAYS == 1) ? '0 : r_way + 1'b1;
      end
      if (r_state == S_RESP && resp_ready) r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_MISS_R && rvalid) r_data[r_way][w_idx][r_beat] <= rdata;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_any_hit) begin
        if (perf_hit != '1) perf_hit <= perf_hit + 32'd1;
      end else if (perf_miss != '1) begin
        perf_miss <= perf_miss + 32'd1;
      end
    end
  end
`endif

  assign req_ready  = (r_state == S_IDLE) && !r_flush_pend && !fence_i;
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_data[r_way][w_idx][w_word];
  assign resp_err   = (r_state == S_RESP) && r_err;
  assign araddr     = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign arvalid    = (r_state == S_MISS_AR);
  assign arlen      = 8'(BEATS - 1);
  assign arsize     = 3'(BW);
  assign arburst    = BURST_INCR;
  assign rready     = (r_state == S_MISS_R);

endmodule
